move_queue_sched: RTL and testbench

Sequences coordinated-move segments between the SPI command decoder and the DDA step generator. Holds a ring buffer of segment descriptors (dir, duration, increment, increment-increment) and issues them one at a time to the DDA. Retires each segment on the DDA's completion pulse and provides flow control (buffer DTR), move-done events, abort/flush and a sticky underrun flag. Sits between the SPI word state machine and the stepper timing datapath.

---
 rtl/move_queue_sched.sv | 245 ++++++++++++++++++++++++
 tb/tb_move_queue_sched.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_queue_sched.sv
// -----------------------------------------------------------------------------
// move_queue_sched
//
// Purpose:
//   Ring buffer of coordinated-move segment descriptors sitting between the SPI
//   command decoder (write side) and the DDA step generator (issue side).
//   Segments are offered to the DDA one at a time. Each segment stays at the
//   head until the DDA reports completion, and is retired only then. The
//   block also provides:
//     - flow control to the decoder (buffer_dtr),
//     - a move_done pulse per retired segment,
//     - abort/flush with a seg_abort pulse to the DDA,
//     - a sticky underrun flag.
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   wr_valid / wr_ready         decoder -> queue segment handshake
//   wr_dir, wr_duration,
//   wr_increment, wr_incinc     segment descriptor being written
//   seg_valid / seg_ready       queue -> DDA head-segment offer
//   seg_dir, seg_duration,
//   seg_increment, seg_incinc   head descriptor (entry at the read pointer)
//   seg_done                    DDA pulse: active segment finished
//   seg_abort                   pulse to DDA: drop active segment
//   abort                       flush request (pulse or level)
//   clr_underrun                clears the sticky underrun flag
//   count                       occupied entries, including the active segment
//   buffer_dtr                  queue not full
//   move_done                   one-cycle pulse per retired segment
//   underrun                    sticky: queue ran dry while the motor was moving
//   busy                        scheduler FSM not in IDLE
//
// Handshake semantics (both interfaces):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   wr_ready depends only on the occupancy and on abort, never on wr_valid.
//   A wr_valid that is not matched by wr_ready is dropped, so the decoder
//   holds or retries. seg_valid depends only on the FSM state, never on
//   seg_ready, and the head fields stay stable from the offer until the
//   segment retires.
// -----------------------------------------------------------------------------
module move_queue_sched #(
  parameter int DEPTH_BITS = 2,
  parameter int W          = 64
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic                  wr_dir,
  input  logic [W-1:0]          wr_duration,
  input  logic [W-1:0]          wr_increment,
  input  logic [W-1:0]          wr_incinc,
  output logic                  seg_valid,
  input  logic                  seg_ready,
  output logic                  seg_dir,
  output logic [W-1:0]          seg_duration,
  output logic [W-1:0]          seg_increment,
  output logic [W-1:0]          seg_incinc,
  input  logic                  seg_done,
  output logic                  seg_abort,
  input  logic                  abort,
  input  logic                  clr_underrun,
  output logic [DEPTH_BITS:0]   count,
  output logic                  buffer_dtr,
  output logic                  move_done,
  output logic                  underrun,
  output logic                  busy
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam int EW    = 3 * W + 1;

  localparam logic [DEPTH_BITS:0]   CNT_ONE = 1;
  localparam logic [DEPTH_BITS-1:0] PTR_ONE = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [EW-1:0]         r_mem [DEPTH];
  logic [DEPTH_BITS-1:0] r_wr_ptr;
  logic [DEPTH_BITS-1:0] r_rd_ptr;
  logic [DEPTH_BITS:0]   r_count;
  logic [DEPTH_BITS:0]   w_count_nxt;

  logic                  r_seg_abort;
  logic                  r_move_done;
  logic                  r_underrun;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_underrun_set;
  logic [EW-1:0]         w_head;
  logic                  w_seg_valid;
  logic                  w_busy;

  // ---------------------------------------------------------------------------
  // Occupancy and handshake qualifiers
  // ---------------------------------------------------------------------------
  // count never exceeds DEPTH, so its MSB is set exactly when the queue is full.
  assign w_full  = r_count[DEPTH_BITS];
  assign w_empty = (r_count == '0);

  assign wr_ready = ~w_full & ~abort;
  assign w_push   = wr_valid & wr_ready;

  // A retire counts only in RUN. abort overrides it, so a done pulse that
  // coincides with a flush neither pops nor produces move_done.
  assign w_pop = (r_state == S_RUN) & seg_done & ~abort;

  always_comb begin
    w_count_nxt = r_count;
    if (abort) begin
      w_count_nxt = '0;
    end else if (w_push && !w_pop) begin
      w_count_nxt = r_count + CNT_ONE;
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - CNT_ONE;
    end
  end

  // The queue runs dry with the motor still moving if the retiring segment
  // left a non-zero increment and nothing follows it. A push in the same
  // cycle keeps the count above zero, so it counts as a follow-on segment.
  assign w_underrun_set = w_pop & (w_count_nxt == '0) & (seg_increment != '0);

  // ---------------------------------------------------------------------------
  // Descriptor storage (not reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {wr_dir, wr_duration, wr_increment, wr_incinc};
    end
  end

  assign w_head = r_mem[r_rd_ptr];
  assign {seg_dir, seg_duration, seg_increment, seg_incinc} = w_head;

  // ---------------------------------------------------------------------------
  // Pointers, count, pulses and sticky flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_seg_abort <= 1'b0;
      r_move_done <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_count     <= w_count_nxt;
      r_move_done <= w_pop;
      // The DDA only holds a segment in ISSUE or RUN, so it only needs to be
      // told to drop one in those states.
      r_seg_abort <= abort & (r_state != S_IDLE);
      // A set in the same cycle as a clear wins.
      r_underrun  <= w_underrun_set | (r_underrun & ~clr_underrun);

      if (abort) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PTR_ONE;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scheduler FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Scheduler FSM: next-state logic
  // ---------------------------------------------------------------------------
  // IDLE looks at the registered count. A push into an empty queue therefore
  // reaches ISSUE one cycle after the push edge.
  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            w_state_nxt = S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (seg_ready) begin
            w_state_nxt = S_RUN;
          end
        end
        S_RUN: begin
          if (seg_done) begin
            w_state_nxt = (w_count_nxt != '0) ? S_ISSUE : S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Scheduler FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_seg_valid = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      S_IDLE:  w_busy      = 1'b0;
      S_ISSUE: w_seg_valid = 1'b1;
      default: w_seg_valid = 1'b0;
    endcase
  end

  assign seg_valid  = w_seg_valid;
  assign busy       = w_busy;
  assign seg_abort  = r_seg_abort;
  assign move_done  = r_move_done;
  assign underrun   = r_underrun;
  assign count      = r_count;
  assign buffer_dtr = ~w_full;

endmodule

// File: tb/tb_move_queue_sched.sv
// -----------------------------------------------------------------------------
// tb_move_queue_sched
//
// Self-checking bench for move_queue_sched with DEPTH_BITS=2 and W=64.
// Segment descriptors go into exp_q as they are accepted and are compared
// when the DUT offers them. Occupancy, wr_ready and underrun are tracked by a
// small model kept in the bench.
// -----------------------------------------------------------------------------
module tb_move_queue_sched;

  localparam int DB    = 2;
  localparam int W     = 64;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic         dir;
    logic [W-1:0] dur;
    logic [W-1:0] inc;
    logic [W-1:0] ii;
  } seg_t;

  typedef struct {
    seg_t s;
    logic exp_under;
  } vec_t;

  // ---------------------------------------------------------------------------
  // DUT signals
  // ---------------------------------------------------------------------------
  logic          clk;
  logic          resetn;
  logic          wr_valid;
  logic          wr_ready;
  logic          wr_dir;
  logic [W-1:0]  wr_duration;
  logic [W-1:0]  wr_increment;
  logic [W-1:0]  wr_incinc;
  logic          seg_valid;
  logic          seg_ready;
  logic          seg_dir;
  logic [W-1:0]  seg_duration;
  logic [W-1:0]  seg_increment;
  logic [W-1:0]  seg_incinc;
  logic          seg_done;
  logic          seg_abort;
  logic          abort;
  logic          clr_underrun;
  logic [DB:0]   count;
  logic          buffer_dtr;
  logic          move_done;
  logic          underrun;
  logic          busy;

  move_queue_sched #(.DEPTH_BITS(DB), .W(W)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_dir        (wr_dir),
    .wr_duration   (wr_duration),
    .wr_increment  (wr_increment),
    .wr_incinc     (wr_incinc),
    .seg_valid     (seg_valid),
    .seg_ready     (seg_ready),
    .seg_dir       (seg_dir),
    .seg_duration  (seg_duration),
    .seg_increment (seg_increment),
    .seg_incinc    (seg_incinc),
    .seg_done      (seg_done),
    .seg_abort     (seg_abort),
    .abort         (abort),
    .clr_underrun  (clr_underrun),
    .count         (count),
    .buffer_dtr    (buffer_dtr),
    .move_done     (move_done),
    .underrun      (underrun),
    .busy          (busy)
  );

  // ---------------------------------------------------------------------------
  // Clock, watchdog and move_done pulse counter
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired, expected finish");
    $fatal(1, "watchdog");
  end

  int md_cnt = 0;
  always @(negedge clk) begin
    if (move_done === 1'b1) md_cnt++;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard and model state
  // ---------------------------------------------------------------------------
  logic [3*W:0] exp_q[$];
  int           checks      = 0;
  int           failures    = 0;
  int           model_count = 0;
  logic         model_under = 1'b0;
  logic [W-1:0] cur_inc     = '0;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic seg_t mk(input logic d, input logic [W-1:0] du,
                              input logic [W-1:0] in, input logic [W-1:0] ii);
    seg_t s;
    s.dir = d;
    s.dur = du;
    s.inc = in;
    s.ii  = ii;
    return s;
  endfunction

  task automatic drive_wr(input seg_t s);
    wr_dir       = s.dir;
    wr_duration  = s.dur;
    wr_increment = s.inc;
    wr_incinc    = s.ii;
    wr_valid     = 1'b1;
  endtask

  // One write attempt; accepted only if the model says there is room.
  task automatic push_seg(input seg_t s);
    logic acc;
    drive_wr(s);
    #1;
    acc = (model_count < DEPTH);
    check("wr_ready", wr_ready, acc);
    cyc();
    wr_valid = 1'b0;
    if (acc) begin
      model_count++;
      exp_q.push_back(s);
    end
    check("count_after_push", count, model_count);
  endtask

  // Wait (bounded) for the offer, compare it against the scoreboard, accept it.
  task automatic issue_seg();
    int n = 0;
    logic [3*W:0] exp;
    while (seg_valid !== 1'b1 && n < 10) begin
      cyc();
      n++;
    end
    if (seg_valid !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout: seg_valid=%b expected 1", seg_valid);
      return;
    end
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL issue_unexpected: seg_valid=1 expected empty queue");
      return;
    end
    exp = exp_q.pop_front();
    cur_inc = exp[2*W-1:W];
    check("seg_fields", {seg_dir, seg_duration, seg_increment, seg_incinc}, exp);
    seg_ready = 1'b1;
    cyc();
    seg_ready = 1'b0;
    check("seg_valid_run", seg_valid, 1'b0);
    check("busy_run", busy, 1'b1);
  endtask

  // Retire the active segment, optionally with a concurrent write attempt.
  task automatic retire_seg(input bit with_push, input seg_t s);
    logic acc;
    acc = 1'b0;
    seg_done = 1'b1;
    if (with_push) drive_wr(s);
    #1;
    if (with_push) begin
      acc = (model_count < DEPTH);
      check("wr_ready_retire", wr_ready, acc);
    end
    cyc();
    seg_done = 1'b0;
    wr_valid = 1'b0;
    if (acc) begin
      model_count++;
      exp_q.push_back(s);
    end
    model_count--;
    if (model_count == 0 && cur_inc != '0) model_under = 1'b1;
    check("move_done", move_done, 1'b1);
    check("count_after_retire", count, model_count);
    check("underrun", underrun, model_under);
    check("reissue_gap", seg_valid, (model_count != 0));
    check("buffer_dtr", buffer_dtr, (model_count < DEPTH));
  endtask

  task automatic clear_underrun();
    clr_underrun = 1'b1;
    cyc();
    clr_underrun = 1'b0;
    model_under  = 1'b0;
    check("underrun_clr", underrun, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  vec_t utab[4];
  seg_t stab[6];
  seg_t dummy;
  int   md_base;

  initial begin
    // Retire-alone vectors: {segment, underrun expected after it retires}.
    utab[0] = '{mk(1'b0, 64'd10, 64'd0,   64'd0),   1'b0};
    utab[1] = '{mk(1'b1, 64'd20, -64'sd3, 64'd0),   1'b1};
    utab[2] = '{mk(1'b0, 64'd30, 64'd0,   64'd7),   1'b0};
    utab[3] = '{mk(1'b1, 64'd40, 64'd5,   -64'sd1), 1'b1};
    for (int i = 0; i < 6; i++) begin
      stab[i] = mk(i[0], 64'(1000 + i), 64'(17 * (i + 1)), 64'(i * 3));
    end
    dummy = mk(1'b1, 64'hDEAD, 64'hBEEF, 64'h1234);

    resetn       = 1'b0;
    wr_valid     = 1'b0;
    wr_dir       = 1'b0;
    wr_duration  = '0;
    wr_increment = '0;
    wr_incinc    = '0;
    seg_ready    = 1'b0;
    seg_done     = 1'b0;
    abort        = 1'b0;
    clr_underrun = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check("rst_seg_valid", seg_valid, 1'b0);
    check("rst_seg_abort", seg_abort, 1'b0);
    check("rst_move_done", move_done, 1'b0);
    check("rst_underrun", underrun, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_buffer_dtr", buffer_dtr, 1'b1);
    check("rst_count", count, 0);
    @(negedge clk);
    resetn = 1'b1;
    cyc();
    check("rst_wr_ready", wr_ready, 1'b1);

    // Single segment: offer latency, run, retire, underrun set and clear
    push_seg(mk(1'b1, 64'd100, 64'd5, 64'd0));
    check("t1_valid_not_yet", seg_valid, 1'b0);
    cyc();
    check("t1_valid_two_cycles", seg_valid, 1'b1);
    issue_seg();
    retire_seg(0, dummy);
    check("t1_busy_idle", busy, 1'b0);
    cyc();
    check("t1_move_done_pulse", move_done, 1'b0);
    clear_underrun();

    // Fill to full, overflow attempt dropped, one retire frees a slot
    for (int i = 0; i < 4; i++) begin
      push_seg(mk(1'b0, 64'(200 + i), 64'(i + 1), 64'd0));
    end
    check("t2_full_dtr", buffer_dtr, 1'b0);
    push_seg(mk(1'b1, 64'd999, 64'd9, 64'd9));
    check("t2_count_full", count, 4);
    issue_seg();
    retire_seg(0, dummy);

    // Write during retire while full is refused; next cycle it is taken
    push_seg(mk(1'b1, 64'd300, 64'd11, 64'd0));
    issue_seg();
    retire_seg(1, mk(1'b0, 64'd301, 64'd12, 64'd0));
    push_seg(mk(1'b0, 64'd302, 64'd13, 64'd0));
    issue_seg();
    retire_seg(0, dummy);
    issue_seg();
    retire_seg(0, dummy);
    // count is 2 here: push and retire together keep it at 2
    issue_seg();
    retire_seg(1, mk(1'b1, 64'd303, 64'd14, 64'd1));
    check("t3_count_stays_2", count, 2);
    while (model_count > 0) begin
      issue_seg();
      retire_seg(0, dummy);
    end
    clear_underrun();

    // Stream 6 segments through the depth-4 ring (pointer wrap)
    md_base = md_cnt;
    for (int i = 0; i < 4; i++) push_seg(stab[i]);
    for (int i = 0; i < 6; i++) begin
      issue_seg();
      retire_seg(0, dummy);
      if (i + 4 < 6) push_seg(stab[i + 4]);
    end
    cyc();
    check("t4_move_done_pulses", md_cnt - md_base, 6);
    check("t4_queue_drained", exp_q.size(), 0);
    clear_underrun();

    // seg_done while a segment is only offered (ISSUE) is ignored
    push_seg(mk(1'b0, 64'd50, 64'd2, 64'd0));
    cyc();
    seg_done = 1'b1;
    cyc();
    seg_done = 1'b0;
    check("t5_done_in_issue_md", move_done, 1'b0);
    check("t5_done_in_issue_cnt", count, 1);
    check("t5_done_in_issue_valid", seg_valid, 1'b1);
    issue_seg();
    retire_seg(0, dummy);
    clear_underrun();

    // Underrun table: each segment retires alone
    for (int i = 0; i < 4; i++) begin
      clear_underrun();
      push_seg(utab[i].s);
      issue_seg();
      retire_seg(0, dummy);
      check("t6_underrun_tbl", underrun, utab[i].exp_under);
    end

    // Abort in RUN with count=3, concurrent seg_done and write; underrun is 1
    for (int i = 0; i < 3; i++) push_seg(mk(1'b1, 64'(400 + i), 64'(i + 7), 64'd0));
    issue_seg();
    md_base = md_cnt;
    abort    = 1'b1;
    seg_done = 1'b1;
    drive_wr(dummy);
    #1;
    check("t7_wr_ready_abort", wr_ready, 1'b0);
    cyc();
    abort    = 1'b0;
    seg_done = 1'b0;
    wr_valid = 1'b0;
    exp_q.delete();
    model_count = 0;
    check("t7_seg_abort", seg_abort, 1'b1);
    check("t7_count", count, 0);
    check("t7_busy", busy, 1'b0);
    check("t7_move_done", move_done, 1'b0);
    check("t7_underrun_kept", underrun, 1'b1);
    cyc();
    check("t7_seg_abort_pulse", seg_abort, 1'b0);
    check("t7_stays_idle", seg_valid, 1'b0);
    check("t7_count_after", count, 0);
    cyc();
    check("t7_no_move_done", md_cnt - md_base, 0);

    // Level abort in IDLE: queue held empty, no seg_abort
    abort = 1'b1;
    drive_wr(dummy);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t8_wr_ready_level", wr_ready, 1'b0);
      cyc();
      check("t8_count_level", count, 0);
      check("t8_seg_abort_idle", seg_abort, 1'b0);
    end
    abort    = 1'b0;
    wr_valid = 1'b0;

    // Queue restarts cleanly from the reset pointers
    push_seg(mk(1'b0, 64'd77, 64'd0, 64'd4));
    issue_seg();
    retire_seg(0, dummy);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
